shared_bus_arbiter: RTL and testbench

SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

---
 rtl/shared_bus_arbiter_if.sv | 29 ++
 rtl/shared_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_shared_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_bus_arbiter_if.sv
// Shared-bus bundle between NUM_CORES cores, the arbiter and one global memory port.
// The arbiter side uses modport master (it masters the memory bus); cores and memory use slave.
interface shared_bus_arbiter_if #(
  parameter int NUM_CORES = 4
);
  logic [16*NUM_CORES-1:0] core_addr;
  logic [NUM_CORES-1:0]    core_wren;
  logic [NUM_CORES-1:0]    core_rden;
  logic [16*NUM_CORES-1:0] core_write_val;
  logic [NUM_CORES-1:0]    core_ready;
  logic [16*NUM_CORES-1:0] core_read_val;
  logic [15:0]             mem_addr;
  logic                    mem_wren;
  logic                    mem_rden;
  logic [15:0]             mem_write_val;
  logic                    mem_ack;
  logic [15:0]             mem_read_val;
  logic                    bus_error;

  modport master (
    input  core_addr, core_wren, core_rden, core_write_val, mem_ack, mem_read_val,
    output core_ready, core_read_val, mem_addr, mem_wren, mem_rden, mem_write_val, bus_error
  );

  modport slave (
    output core_addr, core_wren, core_rden, core_write_val, mem_ack, mem_read_val,
    input  core_ready, core_read_val, mem_addr, mem_wren, mem_rden, mem_write_val, bus_error
  );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter granting one core at a time onto a single memory port (IDLE/BUSY/DONE).
// Optional BUSY timeout with sticky bus_error is enabled by defining SHARED_ARB_TIMEOUT_EN.
module shared_bus_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_bus_arbiter_if.master bus
);
  localparam int DATA_W = 16;
  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  if (NUM_CORES < 2 || NUM_CORES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("shared_bus_arbiter: unsupported NUM_CORES or TIMEOUT_CYCLES");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  read_val_q [NUM_CORES];
  logic               rv_load;
  logic [DATA_W-1:0]  rv_data;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] ready;
  logic               req_any;
  logic [IDX_W-1:0]   pick;
  logic [DATA_W-1:0]  core_addr_a  [NUM_CORES];
  logic [DATA_W-1:0]  core_wdata_a [NUM_CORES];
  logic               to_hit;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign core_addr_a[i]  = bus.core_addr[DATA_W*i +: DATA_W];
    assign core_wdata_a[i] = bus.core_write_val[DATA_W*i +: DATA_W];
    assign bus.core_read_val[DATA_W*i +: DATA_W] = read_val_q[i];
  end

  assign req = bus.core_wren | bus.core_rden;

  // Search starts one past the last grant so every requester is served within NUM_CORES-1 transfers.
  always_comb begin
    int cand;
    req_any = 1'b0;
    pick    = last_grant_q;
    cand    = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!req_any && req[cand[IDX_W-1:0]]) begin
        req_any = 1'b1;
        pick    = cand[IDX_W-1:0];
      end
    end
  end

`ifdef SHARED_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            bus_error_q, bus_error_d;

  assign to_hit        = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign bus.bus_error = bus_error_q;
`else
  assign to_hit        = 1'b0;
  assign bus.bus_error = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    rv_load      = 1'b0;
    rv_data      = bus.mem_read_val;
`ifdef SHARED_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q + TO_W'(1);
    bus_error_d  = bus_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d      = BUSY;
          last_grant_d = pick;
          addr_d       = core_addr_a[pick];
          wdata_d      = core_wdata_a[pick];
          wr_d         = bus.core_wren[pick];
`ifdef SHARED_ARB_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          state_d = DONE;
          rv_load = !wr_q;
        end else if (to_hit) begin
          state_d = DONE;
          rv_load = !wr_q;
          rv_data = 16'hDEAD;
`ifdef SHARED_ARB_TIMEOUT_EN
          bus_error_d = 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_CORES - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) read_val_q[i] <= '0;
`ifdef SHARED_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      bus_error_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      if (rv_load) read_val_q[last_grant_q] <= rv_data;
`ifdef SHARED_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      bus_error_q  <= bus_error_d;
`endif
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == DONE) ready[last_grant_q] = 1'b1;
  end

  assign bus.core_ready    = ready;
  assign bus.mem_wren      = (state_q == BUSY) &&  wr_q;
  assign bus.mem_rden      = (state_q == BUSY) && !wr_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_write_val = wdata_q;
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Scoreboard bench for shared_bus_arbiter: directed transfers, expected responses queued at issue.
module tb_shared_bus_arbiter;
  localparam int NC = 4;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_bus_arbiter_if #(.NUM_CORES(NC)) bif ();
  shared_bus_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  typedef struct {
    int          core;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          busy;
    int          gap;
    bit          acked;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          ack_delay = 1;
  int          mem_cnt   = 0;
  logic [15:0] shadow    [NC];
  int          grants    [NC];
  int          rearm     [NC];
  logic [15:0] next_addr [NC];
  int          g0        [NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (a == 16'h4010) return 16'h1234;
    return {a[7:0], a[15:8]};
  endfunction

  // Memory: acks on the ack_delay-th strobe cycle; updates just after the rising edge.
  initial begin : mem_responder
    bif.mem_ack      = 1'b0;
    bif.mem_read_val = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.mem_wren || bif.mem_rden) begin
        mem_cnt++;
        bif.mem_ack      = (mem_cnt == ack_delay);
        bif.mem_read_val = bif.mem_ack ? mem_rd(bif.mem_addr) : 16'h0;
      end else begin
        mem_cnt          = 0;
        bif.mem_ack      = 1'b0;
        bif.mem_read_val = 16'h0;
      end
    end
  end

  int   m_cyc = 0, m_strobe = 0, m_last = -1;
  bit   m_prev_ack = 1'b0, m_rv_pend = 1'b0;
  exp_t m_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      m_cyc++;
      if (reset) begin
        exp_q.delete();
        m_strobe = 0; m_prev_ack = 1'b0; m_rv_pend = 1'b0; m_last = -1;
        for (int i = 0; i < NC; i++) shadow[i] = 16'h0;
      end else begin
        if (m_rv_pend) begin
          for (int i = 0; i < NC; i++)
            check($sformatf("read_val_core%0d", i), bif.core_read_val[i*16 +: 16], shadow[i]);
          m_rv_pend = 1'b0;
        end
        if (bif.mem_wren || bif.mem_rden) begin
          m_strobe++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_unexpected actual addr=%h required no access", bif.mem_addr);
          end else begin
            m_e = exp_q[0];
            check("mem_op", {bif.mem_wren, bif.mem_rden}, {m_e.wr, !m_e.wr});
            check("mem_addr", bif.mem_addr, m_e.addr);
            if (m_e.wr) check("mem_wdata", bif.mem_write_val, m_e.wdata);
          end
        end
        if (m_prev_ack) check("ready_after_ack", |bif.core_ready, 1);
        if (bif.core_ready != '0) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ready_unexpected actual=%h required=0", bif.core_ready);
          end else begin
            m_e = exp_q.pop_front();
            check("ready_onehot", bif.core_ready, 32'(1) << m_e.core);
            check("busy_cycles", m_strobe, m_e.busy);
            check("acked", m_prev_ack, m_e.acked);
            if (m_e.gap > 0) check("grant_gap", m_cyc - m_last, m_e.gap);
            m_last = m_cyc;
            if (!m_e.wr) shadow[m_e.core] = m_e.rdata;
            grants[m_e.core]++;
            m_rv_pend = 1'b1;
          end
          m_strobe = 0;
        end
        m_prev_ack = (bif.mem_wren || bif.mem_rden) && bif.mem_ack;
      end
    end
  end

  task automatic push(input int c, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] rd, input int busy, input int gap, input bit acked);
    exp_t e;
    e.core = c; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd;
    e.busy = busy; e.gap = gap; e.acked = acked;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int c, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bif.core_addr[c*16 +: 16]      = a;
    bif.core_write_val[c*16 +: 16] = d;
    bif.core_wren[c]               = wr;
    bif.core_rden[c]               = !wr;
  endtask

  // A core keeps its request until it sees its ready, then re-arms or drops it.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      if (bif.core_ready[i]) begin
        if (rearm[i] > 0) begin
          rearm[i]--;
          next_addr[i] = next_addr[i] + 16'h1;
          bif.core_addr[i*16 +: 16] = next_addr[i];
        end else begin
          bif.core_wren[i] = 1'b0;
          bif.core_rden[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (((bif.core_wren | bif.core_rden) != '0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    step();
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] a;
    bif.core_addr      = '0;
    bif.core_write_val = '0;
    bif.core_wren      = '0;
    bif.core_rden      = '0;
    for (int i = 0; i < NC; i++) begin
      rearm[i] = 0; grants[i] = 0; next_addr[i] = 16'h0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", bif.core_ready, 0);
    check("rst_strobes", {bif.mem_wren, bif.mem_rden}, 0);
    check("rst_mem_addr", bif.mem_addr, 0);
    check("rst_mem_wdata", bif.mem_write_val, 0);
    check("rst_bus_error", bif.bus_error, 0);
    for (int i = 0; i < NC; i++) check("rst_read_val", bif.core_read_val[i*16 +: 16], 0);
    reset = 1'b0;
    step();

    // Cores 0,1,3 together: grants 0,1,3 three cycles apart.
    push(0, 1'b0, 16'h0100, 16'h0000, 16'h0001, 1, 0, 1'b1);
    push(1, 1'b1, 16'h0200, 16'hA1A1, 16'h0000, 1, 3, 1'b1);
    push(3, 1'b0, 16'h0300, 16'h0000, 16'h0003, 1, 3, 1'b1);
    set_req(0, 1'b0, 16'h0100, 16'h0000);
    set_req(1, 1'b1, 16'h0200, 16'hA1A1);
    set_req(3, 1'b0, 16'h0300, 16'h0000);
    run_idle(50);

    // Core 2 read acked in its first BUSY cycle.
    push(2, 1'b0, 16'h4010, 16'h0000, 16'h1234, 1, 0, 1'b1);
    set_req(2, 1'b0, 16'h4010, 16'h0000);
    run_idle(50);

    // Core 1 write with the ack delayed to the fifth strobe cycle.
    ack_delay = 5;
    push(1, 1'b1, 16'h8000, 16'hBEEF, 16'h0000, 5, 0, 1'b1);
    set_req(1, 1'b1, 16'h8000, 16'hBEEF);
    run_idle(50);

    // A request that drops while another core is busy must never reach memory.
    ack_delay = 4;
    push(0, 1'b1, 16'h0500, 16'h5555, 16'h0000, 4, 0, 1'b1);
    set_req(0, 1'b1, 16'h0500, 16'h5555);
    step();
    step();
    set_req(1, 1'b0, 16'h0600, 16'h0000);
    step();
    bif.core_rden[1] = 1'b0;
    run_idle(50);

    // Reset in the middle of a read: immediate clear, no ready, priority back to core 0.
    ack_delay = 100000;
    push(2, 1'b0, 16'h4010, 16'h0000, 16'h1234, 1, 0, 1'b1);
    set_req(2, 1'b0, 16'h4010, 16'h0000);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rden", bif.mem_rden, 0);
    check("async_rst_ready", bif.core_ready, 0);
    check("async_rst_read_val2", bif.core_read_val[47:32], 0);
    bif.core_rden[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    ack_delay = 1;
    push(0, 1'b0, 16'h0700, 16'h0000, 16'h0007, 1, 0, 1'b1);
    push(3, 1'b0, 16'h0800, 16'h0000, 16'h0008, 1, 3, 1'b1);
    set_req(0, 1'b0, 16'h0700, 16'h0000);
    set_req(3, 1'b0, 16'h0800, 16'h0000);
    run_idle(50);

    // All cores requesting continuously for 40 transfers: strict rotation 0,1,2,3.
    for (int i = 0; i < NC; i++) g0[i] = grants[i];
    for (int t = 0; t < 40; t++) begin
      a = 16'(16'h2000 + (t % NC) * 256 + t / NC);
      push(t % NC, 1'b0, a, 16'h0000, {a[7:0], a[15:8]}, 1, (t == 0) ? 0 : 3, 1'b1);
    end
    for (int i = 0; i < NC; i++) begin
      next_addr[i] = 16'(16'h2000 + i * 256);
      rearm[i]     = 9;
      set_req(i, 1'b0, next_addr[i], 16'h0000);
    end
    run_idle(400);
    for (int i = 0; i < NC; i++) check($sformatf("grants_core%0d", i), grants[i] - g0[i], 10);

`ifdef SHARED_ARB_TIMEOUT_EN
    ack_delay = 100000;
    push(2, 1'b0, 16'h0900, 16'h0000, 16'hDEAD, TO, 0, 1'b0);
    set_req(2, 1'b0, 16'h0900, 16'h0000);
    run_idle(TO + 50);
    check("bus_error_set", bif.bus_error, 1);
    ack_delay = 1;
    push(1, 1'b1, 16'h0A00, 16'h0101, 16'h0000, 1, 0, 1'b1);
    set_req(1, 1'b1, 16'h0A00, 16'h0101);
    run_idle(50);
    check("bus_error_sticky", bif.bus_error, 1);
`else
    check("bus_error_tied0", bif.bus_error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
